sc_fifo_native: RTL and testbench

Native single-clock FIFO that replaces the vendor-IP-wrapped FIFO in the datapath. It is inferred RAM plus pointer and counter logic, so it is portable across device families. Unlike the previous generation, it honours `SHOWAHEAD`/`REGISTER_OUTPUT`, reports a full-depth word count, and flags rejected requests. It sits between any producer/consumer pair in the same clock domain.

---
 rtl/sc_fifo_native.sv | 116 +++++++++++
 tb/tb_sc_fifo_native.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_native.sv
// Single-clock FIFO on inferred RAM with registered flags, full-depth word count
// and overflow/underflow pulses. Supports look-ahead or normal (optionally registered) output.
module sc_fifo_native #(
    parameter int DWIDTH             = 16,
    parameter int AWIDTH             = 8,
    parameter int SHOWAHEAD          = 1,
    parameter int REGISTER_OUTPUT    = 0,
    parameter int ALMOST_FULL_VALUE  = 240,
    parameter int ALMOST_EMPTY_VALUE = 15
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);
    localparam int              DEPTH   = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] AF_C    = ALMOST_FULL_VALUE[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_C    = ALMOST_EMPTY_VALUE[AWIDTH:0];

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AWIDTH:0]   cnt_nxt;
    logic              wr_ok, rd_ok;

    // Acceptance uses the registered flags, so a full FIFO rejects a write even with a read pending.
    always_comb begin
        wr_ok      = wrreq_i && !full_o;
        rd_ok      = rdreq_i && !empty_o;
        rd_ptr_nxt = rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
        cnt_nxt    = usedw_o;
        if (wr_ok && !rd_ok)
            cnt_nxt = usedw_o + CNT_ONE;
        else if (rd_ok && !wr_ok)
            cnt_nxt = usedw_o - CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr         <= rd_ptr_nxt;
            usedw_o        <= cnt_nxt;
            empty_o        <= (cnt_nxt == '0);
            full_o         <= (cnt_nxt == DEPTH_C);
            almost_full_o  <= (cnt_nxt >= AF_C);
            almost_empty_o <= (cnt_nxt < AE_C);
            overflow_o     <= wrreq_i && full_o;
            underflow_o    <= rdreq_i && empty_o;
        end
    end

    if (SHOWAHEAD != 0) begin : g_sa
        if (REGISTER_OUTPUT != 0) begin : g_bad_cfg
            $error("sc_fifo_native: REGISTER_OUTPUT requires SHOWAHEAD=0");
        end
        // Head word after this edge; bypass data_i when the head is being written right now.
        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i)
                q_o <= '0;
            else if (cnt_nxt != '0)
                q_o <= (wr_ok && (rd_ptr_nxt == wr_ptr)) ? data_i : mem[rd_ptr_nxt];
        end
    end else begin : g_nm
        logic [DWIDTH-1:0] q_rd;

        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i)
                q_rd <= '0;
            else if (rd_ok)
                q_rd <= mem[rd_ptr];
        end

        if (REGISTER_OUTPUT != 0) begin : g_ro
            logic rd_vld;
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    rd_vld <= 1'b0;
                    q_o    <= '0;
                end else begin
                    rd_vld <= rd_ok;
                    if (rd_vld)
                        q_o <= q_rd;
                end
            end
        end else begin : g_direct
            assign q_o = q_rd;
        end
    end
endmodule

// File: tb/tb_sc_fifo_native.sv
// Directed and randomized checks of sc_fifo_native in showahead, normal and
// registered-normal modes, driven in lock-step from shared stimulus.
module tb_sc_fifo_native;
    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [15:0] data = '0;
    logic        wrreq = 1'b0, rdreq = 1'b0;

    logic [15:0] a_q, b_q, c_q;
    logic [8:0]  a_usedw, b_usedw, c_usedw;
    logic        a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
    logic        b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
    logic        c_empty, c_full, c_af, c_ae, c_ovf, c_unf;

    sc_fifo_native #(.SHOWAHEAD(1), .REGISTER_OUTPUT(0)) u_sa (
        .clk_i(clk), .arst_i(arst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(a_q), .empty_o(a_empty), .full_o(a_full), .usedw_o(a_usedw),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf), .underflow_o(a_unf));

    sc_fifo_native #(.SHOWAHEAD(0), .REGISTER_OUTPUT(0)) u_nm (
        .clk_i(clk), .arst_i(arst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(b_q), .empty_o(b_empty), .full_o(b_full), .usedw_o(b_usedw),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ovf), .underflow_o(b_unf));

    sc_fifo_native #(.SHOWAHEAD(0), .REGISTER_OUTPUT(1)) u_ro (
        .clk_i(clk), .arst_i(arst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(c_q), .empty_o(c_empty), .full_o(c_full), .usedw_o(c_usedw),
        .almost_full_o(c_af), .almost_empty_o(c_ae), .overflow_o(c_ovf), .underflow_o(c_unf));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] qm[$];
    logic [15:0] ea, eb, ec, cval;
    bit          cpend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qm.delete();
        ea = '0; eb = '0; ec = '0; cval = '0; cpend = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_full"},  32'(a_full),  32'd0);
        chk({tag, "_usedw"}, 32'(a_usedw), 32'd0);
        chk({tag, "_ae"},    32'(a_ae),    32'd1);
        chk({tag, "_af"},    32'(a_af),    32'd0);
        chk({tag, "_ovf"},   32'(a_ovf),   32'd0);
        chk({tag, "_unf"},   32'(a_unf),   32'd0);
        chk({tag, "_q_sa"},  32'(a_q),     32'd0);
        chk({tag, "_q_nm"},  32'(b_q),     32'd0);
        chk({tag, "_q_ro"},  32'(c_q),     32'd0);
        chk({tag, "_usedw_ro"}, 32'(c_usedw), 32'd0);
    endtask

    // One clock with the given requests; the reference queue tracks all three instances.
    task automatic cyc(input bit w, input bit r, input logic [15:0] d);
        bit          wok, rok;
        logic [15:0] pop;
        int          n;
        wrreq = w; rdreq = r; data = d;
        wok = w && (qm.size() < 256);
        rok = r && (qm.size() > 0);
        @(posedge clk); #1;
        pop = '0;
        if (rok) pop = qm.pop_front();
        if (wok) qm.push_back(d);
        if (cpend) ec = cval;
        cpend = rok;
        cval  = pop;
        if (rok) eb = pop;
        if (qm.size() > 0) ea = qm[0];
        n = qm.size();
        chk("usedw", 32'(a_usedw), 32'(n));
        chk("empty", 32'(a_empty), 32'(n == 0));
        chk("full",  32'(a_full),  32'(n == 256));
        chk("af",    32'(a_af),    32'(n >= 240));
        chk("ae",    32'(a_ae),    32'(n < 15));
        chk("ovf",   32'(a_ovf),   32'(w && !wok));
        chk("unf",   32'(a_unf),   32'(r && !rok));
        chk("q_sa",  32'(a_q),     32'(ea));
        chk("q_nm",  32'(b_q),     32'(eb));
        chk("q_ro",  32'(c_q),     32'(ec));
        chk("usedw_nm", 32'(b_usedw), 32'(n));
        chk("usedw_ro", 32'(c_usedw), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        #2 arst = 1'b1;
        #1 chk_rst("por");
        @(posedge clk); #1;
        arst = 1'b0;

        // Fill 0x0001..0x0100 back-to-back
        for (int i = 1; i <= 256; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            if (i == 1)   chk("fill_q_first", 32'(a_q), 32'h0001);
            if (i == 239) chk("af_239", 32'(a_af), 32'd0);
            if (i == 240) chk("af_240", 32'(a_af), 32'd1);
            if (i == 255) chk("full_255", 32'(a_full), 32'd0);
            if (i == 256) chk("full_256", 32'(a_full), 32'd1);
        end
        cyc(1'b1, 1'b0, 16'h0101);
        chk("w257_ovf", 32'(a_ovf), 32'd1);
        chk("w257_usedw", 32'(a_usedw), 32'd256);

        // Simultaneous at full: read wins, write rejected
        cyc(1'b1, 1'b1, 16'hBEEF);
        chk("rw256_usedw", 32'(a_usedw), 32'd255);
        chk("rw256_ovf", 32'(a_ovf), 32'd1);
        chk("rw256_q_sa", 32'(a_q), 32'h0002);
        chk("rw256_q_nm", 32'(b_q), 32'h0001);

        for (int i = 0; i < 127; i++) cyc(1'b0, 1'b1, 16'h0);
        chk("drain_usedw", 32'(a_usedw), 32'd128);
        chk("drain_q_sa", 32'(a_q), 32'h0081);

        cyc(1'b1, 1'b1, 16'h1234);
        chk("rw128_usedw", 32'(a_usedw), 32'd128);
        chk("rw128_q_sa", 32'(a_q), 32'h0082);
        chk("rw128_q_nm", 32'(b_q), 32'h0081);

        // Async reset mid-burst at count 100
        for (int i = 0; i < 28; i++) cyc(1'b0, 1'b1, 16'h0);
        chk("pre_rst_usedw", 32'(a_usedw), 32'd100);
        #2 arst = 1'b1;
        #1 chk_rst("arst");
        model_reset();
        @(posedge clk); #1;
        arst = 1'b0; rdreq = 1'b0;

        // Showahead single word
        cyc(1'b1, 1'b0, 16'hA5A5);
        chk("sa_q", 32'(a_q), 32'hA5A5);
        chk("sa_empty", 32'(a_empty), 32'd0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("sa_rd_empty", 32'(a_empty), 32'd1);
        chk("sa_rd_usedw", 32'(a_usedw), 32'd0);
        chk("sa_rd_q_nm", 32'(b_q), 32'hA5A5);
        cyc(1'b0, 1'b1, 16'h0);
        chk("sa_unf", 32'(a_unf), 32'd1);
        chk("sa_unf_q", 32'(a_q), 32'hA5A5);
        chk("sa_unf_q_ro", 32'(c_q), 32'hA5A5);

        // Normal-mode latency: 1 cycle direct, 2 cycles registered
        cyc(1'b1, 1'b0, 16'h1111);
        cyc(1'b1, 1'b0, 16'h2222);
        cyc(1'b0, 1'b1, 16'h0);
        chk("nm_rd1_q", 32'(b_q), 32'h1111);
        chk("ro_rd1_q", 32'(c_q), 32'hA5A5);
        cyc(1'b0, 1'b1, 16'h0);
        chk("nm_rd2_q", 32'(b_q), 32'h2222);
        chk("ro_rd2_q", 32'(c_q), 32'h1111);
        cyc(1'b0, 1'b0, 16'h0);
        chk("ro_late_q", 32'(c_q), 32'h2222);
        chk("nm_hold_q", 32'(b_q), 32'h2222);

        // Simultaneous at count 0 and 1
        cyc(1'b1, 1'b1, 16'hC0C0);
        chk("rw0_usedw", 32'(a_usedw), 32'd1);
        chk("rw0_unf", 32'(a_unf), 32'd1);
        chk("rw0_q_sa", 32'(a_q), 32'hC0C0);
        cyc(1'b1, 1'b1, 16'hC1C1);
        chk("rw1_usedw", 32'(a_usedw), 32'd1);
        chk("rw1_q_sa", 32'(a_q), 32'hC1C1);
        chk("rw1_unf", 32'(a_unf), 32'd0);
        chk("rw1_q_nm", 32'(b_q), 32'hC0C0);

        // Random traffic in phases: fill-biased, drain-biased, balanced
        for (int i = 0; i < 1000; i++) begin
            int pw, pr;
            pw = (i < 350) ? 80 : (i < 650) ? 25 : 55;
            pr = (i < 350) ? 30 : (i < 650) ? 85 : 50;
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 16'($urandom));
        end
        cyc(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
